twin_stick_mapper: RTL and testbench
====================================

Name: twin_stick_mapper

Overview:
- Parametrised input conditioner between hps_io and the Williams-2 game core.
- Converts MiSTer digital pads and signed analog sticks into per-player 4-bit run/aim direction nibbles, plus fire, start and coin.
- Modes: digital single-stick, dual analog with hysteresis, and single-stick with aim latch.
- Replaces the ad-hoc combinational mapping in the top level; serves any twin-stick Williams title.

Parameters:
PLAYERS, 2, number of player channels (1..4)
AXIS_W, 8, analog axis width; signed two's complement
DEAD_ON, 48, magnitude at or above which an axis direction asserts
DEAD_OFF, 32, magnitude below which an asserted direction releases; must be < DEAD_ON
COIN_CYCLES, 600000, coin output pulse length in clk_sys cycles (50 ms at 12 MHz)
AUTOFIRE_DIV, 4, vblank rising edges per autofire toggle (used only with the optional feature)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
mode  in  2  0=digital single, 1=dual analog, 2=single+aim latch, 3=same as 1
vblank  in  1  frame strobe; rising edge used only by autofire
joy_dig  in  16*PLAYERS  MiSTer digital pads; per player bit0 R, 1 L, 2 D, 3 U, 4 fire, 5 start, 6 coin
joy_l  in  2*AXIS_W*PLAYERS  left sticks; per player {Y,X}, signed, negative = up/left
joy_r  in  2*AXIS_W*PLAYERS  right sticks; same format
autofire_en  in  PLAYERS  per-player autofire request
run  out  4*PLAYERS  per player {U,D,L,R}
aim  out  4*PLAYERS  per player {U,D,L,R}
fire  out  PLAYERS  trigger
start  out  PLAYERS  start
coin  out  1  stretched coin pulse

Behaviour:
- Reset: run, aim, fire, start and coin are 0; all hysteresis, latch and counter state is cleared.
- Pipeline: stage 1 registers all inputs; stage 2 computes and registers the outputs. Latency is exactly 2 clk_sys cycles from input change to output; one result per cycle.
- Axis hysteresis, one positive and one negative flag per axis per stick:
  - pos sets when v >= DEAD_ON and clears when v < DEAD_OFF.
  - neg sets when v <= -DEAD_ON and clears when v > -DEAD_OFF.
  - Compare in AXIS_W+1-bit signed arithmetic. -2^(AXIS_W-1) is a valid full deflection with no overflow.
  - Values between DEAD_OFF and DEAD_ON hold the previous flag.
- Axis direction mapping: X pos = R, X neg = L, Y pos = D, Y neg = U.
- Mode 0: run = aim = digital {U,D,L,R}. Analog flags are held cleared.
- Mode 1/3: run = left-stick flags; aim = right-stick flags. Digital directions are ORed into run only.
- Mode 2:
  - run = digital OR left-stick flags.
  - aim = last non-zero run nibble, latched while run != 0.
  - aim holds after run returns to 0. After reset, aim is 0 until the first non-zero run.
- SOCD: if U and D are both 1 after combining, both are forced to 0. Same for L and R. Applies to run and aim.
- Mode change: detected when the registered mode differs from the previous cycle. In that cycle, hysteresis flags and the aim latch clear and run/aim outputs are 0; the new mode takes effect the next cycle.
- fire/start: registered copies of bits 4/5, subject to the optional feature.
- Coin:
  - Rising edge of the OR of bit 6 across players loads a counter with COIN_CYCLES; coin = 1 while counter != 0.
  - Edges during an active pulse are ignored, with no retrigger.
  - Holding the coin bit produces exactly one pulse.
- Reset mid-pulse or mid-operation returns everything to reset values on the next edge.

Optional Feature:
- Macro TWIN_STICK_AUTOFIRE_EN.
- Defined:
  - Per player, while autofire_en[p] and fire bit are both 1, fire[p] toggles on every AUTOFIRE_DIV-th vblank rising edge.
  - The first toggle is to 1, on the cycle after the press is registered.
  - Releasing the button forces 0 and clears that player's divider.
- Undefined: autofire_en is ignored, fire = registered fire bit, and no divider logic is synthesised.

Test Plan:
- Reset, then joy_dig p0 = 0x0009 in mode 0 -> run0 = aim0 = 4'b1001 exactly 2 cycles later; all other outputs 0.
- Mode 1, left X ramps 0 -> 48 -> 40 -> 31 -> run0 R bit reads 0, 1, 1, 0. Left X = -128 -> L = 1 with no overflow.
- Mode 1, digital U+D held with left stick neutral -> run0 U/D = 0. Right Y = -60 -> aim0 = 4'b1000.
- Mode 2: press R for 5 cycles, release -> run0 returns to 0 and aim0 stays 4'b0001. Switch to mode 1 -> one cycle of all 0, then aim follows the right stick.
- COIN_CYCLES = 10: coin held 50 cycles -> coin high exactly 10 cycles. A second edge at cycle 5 of the pulse is ignored. Reset at cycle 3 -> coin = 0 next cycle.
- With TWIN_STICK_AUTOFIRE_EN, AUTOFIRE_DIV = 2, fire + autofire_en held over 8 vblanks -> fire0 toggles every 2 vblanks. Release -> 0. Without the macro -> fire0 stays 1.

Source files
------------

// File: rtl/twin_stick_mapper_if.sv
// Pad/stick bundle between hps_io and the twin-stick mapper.
// master = input source (hps_io side), slave = mapper.
interface twin_stick_mapper_if #(
  parameter int PLAYERS = 2,
  parameter int AXIS_W  = 8
);
  logic [16*PLAYERS-1:0]       joy_dig;
  logic [2*AXIS_W*PLAYERS-1:0] joy_l;
  logic [2*AXIS_W*PLAYERS-1:0] joy_r;
  logic [PLAYERS-1:0]          autofire_en;
  logic [4*PLAYERS-1:0]        run;
  logic [4*PLAYERS-1:0]        aim;
  logic [PLAYERS-1:0]          fire;
  logic [PLAYERS-1:0]          start;
  logic                        coin;

  modport master (
    output joy_dig, joy_l, joy_r, autofire_en,
    input  run, aim, fire, start, coin
  );

  modport slave (
    input  joy_dig, joy_l, joy_r, autofire_en,
    output run, aim, fire, start, coin
  );
endinterface

// File: rtl/twin_stick_mapper.sv
// Twin-stick input conditioner for Williams-2 cores.
// Stage 1 registers all inputs, stage 2 computes and registers run/aim/fire/
// start nibbles (2-cycle latency). Analog axes use on/off hysteresis.
// Optional autofire is enabled by defining TWIN_STICK_AUTOFIRE_EN.
module twin_stick_mapper #(
  parameter int PLAYERS      = 2,
  parameter int AXIS_W       = 8,
  parameter int DEAD_ON      = 48,
  parameter int DEAD_OFF     = 32,
  parameter int COIN_CYCLES  = 600000,
  parameter int AUTOFIRE_DIV = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic                      vblank,
  twin_stick_mapper_if.slave        bus
);
  localparam int CNT_W    = $clog2(COIN_CYCLES + 1);
  localparam int NEG_ON   = -DEAD_ON;
  localparam int NEG_OFF  = -DEAD_OFF;
  localparam logic signed [AXIS_W:0] C_ON_P  = DEAD_ON[AXIS_W:0];
  localparam logic signed [AXIS_W:0] C_OFF_P = DEAD_OFF[AXIS_W:0];
  localparam logic signed [AXIS_W:0] C_ON_N  = NEG_ON[AXIS_W:0];
  localparam logic signed [AXIS_W:0] C_OFF_N = NEG_OFF[AXIS_W:0];
  localparam logic [CNT_W-1:0]       C_COIN  = CNT_W'(COIN_CYCLES);

  // Returns {pos, neg} flags after applying hysteresis to one axis sample.
  function automatic logic [1:0] hyst(input logic [AXIS_W-1:0] raw,
                                      input logic pos, input logic neg);
    logic signed [AXIS_W:0] v;
    logic p;
    logic n;
    v = signed'({raw[AXIS_W-1], raw});
    p = pos;
    n = neg;
    if (v >= C_ON_P)       p = 1'b1;
    else if (v < C_OFF_P)  p = 1'b0;
    if (v <= C_ON_N)       n = 1'b1;
    else if (v > C_OFF_N)  n = 1'b0;
    return {p, n};
  endfunction

  // Opposing directions cancel each other.
  function automatic logic [3:0] socd(input logic [3:0] n);
    logic [3:0] o;
    o = n;
    if (n[3] && n[2]) o[3:2] = 2'b00;
    if (n[1] && n[0]) o[1:0] = 2'b00;
    return o;
  endfunction

  logic [1:0]                  r_mode;
  logic [1:0]                  r_mode_prev;
  logic                        r_vblank;
  logic                        r_vblank_prev;
  logic [16*PLAYERS-1:0]       r_joy_dig;
  logic [2*AXIS_W*PLAYERS-1:0] r_joy_l;
  logic [2*AXIS_W*PLAYERS-1:0] r_joy_r;
  logic [PLAYERS-1:0]          r_af_en;
  logic                        r_coin_prev;
  logic [CNT_W-1:0]            r_coin_cnt;
  logic                        w_mode_chg;
  logic                        w_vb_rise;
  logic                        w_coin_any;
  logic                        w_unused;

  // Stage 1: register every input.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mode        <= 2'd0;
      r_mode_prev   <= 2'd0;
      r_vblank      <= 1'b0;
      r_vblank_prev <= 1'b0;
      r_joy_dig     <= '0;
      r_joy_l       <= '0;
      r_joy_r       <= '0;
      r_af_en       <= '0;
    end else begin
      r_mode        <= mode;
      r_mode_prev   <= r_mode;
      r_vblank      <= vblank;
      r_vblank_prev <= r_vblank;
      r_joy_dig     <= bus.joy_dig;
      r_joy_l       <= bus.joy_l;
      r_joy_r       <= bus.joy_r;
      r_af_en       <= bus.autofire_en;
    end
  end

  assign w_mode_chg = (r_mode != r_mode_prev);
  assign w_vb_rise  = r_vblank & ~r_vblank_prev;
  // Bits not consumed by every build configuration are folded here.
  assign w_unused   = ^{r_joy_dig, r_af_en, w_vb_rise};

  // Any player's coin bit can start the pulse.
  always_comb begin
    w_coin_any = 1'b0;
    for (int p = 0; p < PLAYERS; p++) w_coin_any = w_coin_any | r_joy_dig[16*p+6];
  end

  // Coin stretcher: rising edge loads the counter only when idle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_coin_prev <= 1'b0;
      r_coin_cnt  <= '0;
    end else begin
      r_coin_prev <= w_coin_any;
      if (w_coin_any && !r_coin_prev && r_coin_cnt == '0) r_coin_cnt <= C_COIN;
      else if (r_coin_cnt != '0)                            r_coin_cnt <= r_coin_cnt - CNT_W'(1);
    end
  end

  assign bus.coin = (r_coin_cnt != '0);

  genvar gi;
  generate
    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [1:0] r_lp, r_ln, r_rp, r_rn;  // bit0 = X, bit1 = Y
      logic [3:0] r_run, r_aim, r_latch;
      logic       r_fire, r_start;
      logic [1:0] w_lx, w_ly, w_rx, w_ry;  // {pos, neg}
      logic [3:0] w_dig, w_lnib, w_rnib, w_run_dig, w_run_an, w_aim_an;
      logic       w_fire_btn;

      assign w_lx = hyst(r_joy_l[2*AXIS_W*gi +: AXIS_W],          r_lp[0], r_ln[0]);
      assign w_ly = hyst(r_joy_l[2*AXIS_W*gi + AXIS_W +: AXIS_W], r_lp[1], r_ln[1]);
      assign w_rx = hyst(r_joy_r[2*AXIS_W*gi +: AXIS_W],          r_rp[0], r_rn[0]);
      assign w_ry = hyst(r_joy_r[2*AXIS_W*gi + AXIS_W +: AXIS_W], r_rp[1], r_rn[1]);

      // Nibble order {U,D,L,R}: Y neg, Y pos, X neg, X pos.
      assign w_dig      = r_joy_dig[16*gi +: 4];
      assign w_lnib     = {w_ly[0], w_ly[1], w_lx[0], w_lx[1]};
      assign w_rnib     = {w_ry[0], w_ry[1], w_rx[0], w_rx[1]};
      assign w_run_dig  = socd(w_dig);
      assign w_run_an   = socd(w_dig | w_lnib);
      assign w_aim_an   = socd(w_rnib);
      assign w_fire_btn = r_joy_dig[16*gi+4];

      // Stage 2: per-mode direction mapping, hysteresis and aim latch.
      always_ff @(posedge clk_sys) begin
        if (reset || w_mode_chg) begin
          r_lp <= '0; r_ln <= '0; r_rp <= '0; r_rn <= '0;
          r_run <= '0; r_aim <= '0; r_latch <= '0;
        end else begin
          case (r_mode)
            2'd0: begin
              r_lp <= '0; r_ln <= '0; r_rp <= '0; r_rn <= '0;
              r_run <= w_run_dig;
              r_aim <= w_run_dig;
            end
            2'd2: begin
              r_lp <= {w_ly[1], w_lx[1]};
              r_ln <= {w_ly[0], w_lx[0]};
              r_rp <= '0; r_rn <= '0;
              r_run <= w_run_an;
              if (w_run_an != 4'd0) begin
                r_latch <= w_run_an;
                r_aim   <= w_run_an;
              end else begin
                r_aim   <= r_latch;
              end
            end
            default: begin
              r_lp <= {w_ly[1], w_lx[1]};
              r_ln <= {w_ly[0], w_lx[0]};
              r_rp <= {w_ry[1], w_rx[1]};
              r_rn <= {w_ry[0], w_rx[0]};
              r_run <= w_run_an;
              r_aim <= w_aim_an;
            end
          endcase
        end
      end

      // Start is a plain delayed copy of the pad bit.
      always_ff @(posedge clk_sys) begin
        if (reset) r_start <= 1'b0;
        else       r_start <= r_joy_dig[16*gi+5];
      end

`ifdef TWIN_STICK_AUTOFIRE_EN
      localparam int DIV_W = $clog2(AUTOFIRE_DIV + 1);
      logic [DIV_W-1:0] r_af_div;
      logic             r_af_act;

      // Autofire: first press fires at once, then toggles every AUTOFIRE_DIV vblanks.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          r_fire   <= 1'b0;
          r_af_act <= 1'b0;
          r_af_div <= '0;
        end else if (r_af_en[gi] && w_fire_btn) begin
          if (!r_af_act) begin
            r_fire   <= 1'b1;
            r_af_act <= 1'b1;
            r_af_div <= '0;
          end else if (w_vb_rise) begin
            if (r_af_div == DIV_W'(AUTOFIRE_DIV - 1)) begin
              r_af_div <= '0;
              r_fire   <= ~r_fire;
            end else begin
              r_af_div <= r_af_div + DIV_W'(1);
            end
          end
        end else begin
          r_fire   <= w_fire_btn;
          r_af_act <= 1'b0;
          r_af_div <= '0;
        end
      end
`else
      // Fire is a plain delayed copy of the pad bit.
      always_ff @(posedge clk_sys) begin
        if (reset) r_fire <= 1'b0;
        else       r_fire <= w_fire_btn;
      end
`endif

      assign bus.run[4*gi +: 4] = r_run;
      assign bus.aim[4*gi +: 4] = r_aim;
      assign bus.fire[gi]       = r_fire;
      assign bus.start[gi]      = r_start;
    end
  endgenerate
endmodule

// File: tb/tb_twin_stick_mapper.sv
// Directed self-checking bench for twin_stick_mapper (PLAYERS=2, AXIS_W=8,
// COIN_CYCLES=10, AUTOFIRE_DIV=2). Expectations follow TWIN_STICK_AUTOFIRE_EN.
module tb_twin_stick_mapper;
  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] mode    = 2'd0;
  logic       vblank  = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  twin_stick_mapper_if #(.PLAYERS(2), .AXIS_W(8)) bus_if ();

  twin_stick_mapper #(
    .PLAYERS(2), .AXIS_W(8), .DEAD_ON(48), .DEAD_OFF(32),
    .COIN_CYCLES(10), .AUTOFIRE_DIV(2)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .mode    (mode),
    .vblank  (vblank),
    .bus     (bus_if.slave)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic test_reset;
    bus_if.joy_dig = '0; bus_if.joy_l = '0; bus_if.joy_r = '0; bus_if.autofire_en = '0;
    reset = 1'b1;
    tick(2);
    chk("reset_run",   {24'd0, bus_if.run},   32'h0);
    chk("reset_aim",   {24'd0, bus_if.aim},   32'h0);
    chk("reset_fire",  {30'd0, bus_if.fire},  32'h0);
    chk("reset_start", {30'd0, bus_if.start}, 32'h0);
    chk("reset_coin",  {31'd0, bus_if.coin},  32'h0);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_digital;
    mode = 2'd0;
    bus_if.joy_dig = 32'h0000_0009;
    tick(1);
    chk("dig_run_lat1", {24'd0, bus_if.run}, 32'h00);
    tick(1);
    chk("dig_run_lat2", {24'd0, bus_if.run}, 32'h09);
    chk("dig_aim_lat2", {24'd0, bus_if.aim}, 32'h09);
    chk("dig_others",   {29'd0, bus_if.fire, bus_if.coin}, 32'h0);
    bus_if.joy_dig = 32'h0020_0000;
    tick(2);
    chk("dig_start_p1", {30'd0, bus_if.start}, 32'h2);
    bus_if.joy_dig = '0;
    tick(2);
  endtask

  task automatic test_hysteresis;
    logic [7:0] xs [5];
    logic [3:0] exp_r [5];
    xs[0] = 8'd0;  exp_r[0] = 4'b0000;
    xs[1] = 8'd48; exp_r[1] = 4'b0001;
    xs[2] = 8'd40; exp_r[2] = 4'b0001;
    xs[3] = 8'd31; exp_r[3] = 4'b0000;
    xs[4] = 8'h80; exp_r[4] = 4'b0010;
    mode = 2'd1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      bus_if.joy_l[7:0] = xs[i];
      tick(2);
      chk($sformatf("hyst_x_%0d", i), {28'd0, bus_if.run[3:0]}, {28'd0, exp_r[i]});
    end
    bus_if.joy_l = '0;
    tick(2);
  endtask

  task automatic test_socd;
    mode = 2'd1;
    bus_if.joy_dig = 32'h0000_000C;
    tick(2);
    chk("socd_ud", {28'd0, bus_if.run[3:0]}, 32'h0);
    bus_if.joy_dig = 32'h0000_0009;
    tick(2);
    chk("socd_ur", {28'd0, bus_if.run[3:0]}, 32'h9);
    bus_if.joy_dig = '0;
    bus_if.joy_r[15:8] = 8'hC4;  // -60
    tick(2);
    chk("aim_right_up", {28'd0, bus_if.aim[3:0]}, 32'h8);
    chk("aim_run_idle", {28'd0, bus_if.run[3:0]}, 32'h0);
    bus_if.joy_r = '0;
    tick(2);
  endtask

  task automatic test_aim_latch;
    mode = 2'd2;
    tick(3);
    chk("latch_init", {28'd0, bus_if.aim[3:0]}, 32'h0);
    bus_if.joy_dig = 32'h0000_0001;
    tick(2);
    chk("latch_run_r", {28'd0, bus_if.run[3:0]}, 32'h1);
    chk("latch_aim_r", {28'd0, bus_if.aim[3:0]}, 32'h1);
    tick(3);
    bus_if.joy_dig = '0;
    tick(2);
    chk("latch_run_rel", {28'd0, bus_if.run[3:0]}, 32'h0);
    chk("latch_aim_hold", {28'd0, bus_if.aim[3:0]}, 32'h1);
    bus_if.joy_r[15:8] = 8'hC4;
    mode = 2'd1;
    tick(1);
    chk("modechg_pre", {28'd0, bus_if.aim[3:0]}, 32'h1);
    tick(1);
    chk("modechg_zero", {24'd0, bus_if.aim[3:0], bus_if.run[3:0]}, 32'h0);
    tick(1);
    chk("modechg_aim", {28'd0, bus_if.aim[3:0]}, 32'h8);
    bus_if.joy_r = '0;
    tick(3);
  endtask

  task automatic test_coin;
    int highs;
    highs = 0;
    bus_if.joy_dig = 32'h0000_0040;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (i == 1) chk("coin_lat1", {31'd0, bus_if.coin}, 32'h0);
      if (i == 2) chk("coin_lat2", {31'd0, bus_if.coin}, 32'h1);
      if (bus_if.coin) highs++;
    end
    chk("coin_held_len", highs, 32'd10);
    bus_if.joy_dig = '0;
    tick(3);
    highs = 0;
    bus_if.joy_dig = 32'h0040_0000;  // player 1 coin
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (bus_if.coin) highs++;
      if (i == 1) bus_if.joy_dig = '0;
      if (i == 6) bus_if.joy_dig = 32'h0000_0040;
      if (i == 9) bus_if.joy_dig = '0;
    end
    chk("coin_no_retrig", highs, 32'd10);
    bus_if.joy_dig = 32'h0000_0040;
    tick(1);
    bus_if.joy_dig = '0;
    tick(3);
    chk("coin_mid_pulse", {31'd0, bus_if.coin}, 32'h1);
    reset = 1'b1;
    tick(1);
    chk("coin_reset", {31'd0, bus_if.coin}, 32'h0);
    reset = 1'b0;
    tick(4);
    chk("coin_after_rst", {31'd0, bus_if.coin}, 32'h0);
  endtask

  task automatic test_autofire;
    logic exp_fire;
    bus_if.autofire_en = 2'b01;
    bus_if.joy_dig = 32'h0000_0010;
    tick(2);
    chk("af_press", {31'd0, bus_if.fire[0]}, 32'h1);
    exp_fire = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      vblank = 1'b1;
      tick(1);
      vblank = 1'b0;
      tick(3);
`ifdef TWIN_STICK_AUTOFIRE_EN
      if (v % 2 == 0) exp_fire = ~exp_fire;
`endif
      chk($sformatf("af_vblank_%0d", v), {31'd0, bus_if.fire[0]}, {31'd0, exp_fire});
    end
    bus_if.joy_dig = '0;
    tick(2);
    chk("af_release", {31'd0, bus_if.fire[0]}, 32'h0);
    bus_if.autofire_en = '0;
  endtask

  initial begin
    bus_if.joy_dig = '0; bus_if.joy_l = '0; bus_if.joy_r = '0; bus_if.autofire_en = '0;
    test_reset();
    test_digital();
    test_hysteresis();
    test_socd();
    test_aim_latch();
    test_coin();
    test_autofire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
